aes_enc_pipe: RTL and testbench
===============================

# aes_enc_pipe

Parametrised, fully unrolled AES encryption pipeline supporting AES-128/192/256 via the round count NR, with a ready/valid handshake on both sides, per-stage valid tracking with bubble collapse, a sideband tag carried alongside each block, and a synchronous flush. It sits between the key-expansion block, which supplies the full expanded schedule, and the data interface that streams 128-bit blocks. It supersedes the fixed 10-round, always-advancing encryption pipeline.

## Interface
- NR, default 10: number of AES rounds; legal values are 10, 12 and 14. Any other value is a elaboration error.
- TAG_W, default 8: width of the sideband tag; TAG_W ≥ 1.
- NW, derived as 4*(NR+1): number of 32-bit key schedule words.
- clk  in  1  clock; all registers update on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all in-flight blocks.
- key_schedule  in  32*NW  expanded key; word w[i] = key_schedule[32*NW-1-32*i -: 32], so w[0] is at the MSBs.
- in_valid  in  1  the input block is offered.
- in_ready  out  1  stage 0 can accept this cycle.
- d_in  in  128  plaintext; byte 0 = d_in[127:120], FIPS-197 column-major order.
- tag_in  in  TAG_W  sideband value carried with the block.
- out_valid  out  1  d_out and tag_out hold a result.
- out_ready  in  1  the consumer accepts the result.
- d_out  out  128  ciphertext, same byte order as d_in.
- tag_out  out  TAG_W  tag of the block in d_out.
- busy  out  1  at least one stage valid.
- occupancy  out  $clog2(NR+2)  count of valid stages, 0..NR+1.

## Operation
- Stages S[0..NR]: NR+1 state registers, each with a valid bit v[k] and a tag register.
  - S[0] <= d_in XOR {w0,w1,w2,w3} (initial AddRoundKey).
  - S[k] <= Round_k(S[k-1]) for k = 1..NR-1. Round_k is SubBytes, then ShiftRows, then MixColumns, then AddRoundKey with w[4k..4k+3].
  - S[NR] <= FinalRound(S[NR-1]). FinalRound omits MixColumns and uses w[4NR..4NR+3].
  - S[NR] drives d_out and tag_out directly; v[NR] drives out_valid.
- Advance enables, combinational and computed from the output side back:
  - adv[NR] = !v[NR] | out_ready.
  - adv[k] = !v[k] | adv[k+1], for k < NR.
  - in_ready = adv[0].
  - Stage k loads when adv[k]=1. Its new valid is v[k-1], or in_valid & in_ready for stage 0.
  - A stalled stage holds its data, tag and valid.
- Bubble collapse: an empty stage accepts from upstream even while downstream is stalled. The pipeline therefore absorbs up to NR+1 blocks under sustained backpressure.
- Data registers load even when the incoming valid is 0. Their contents are don't-care while v=0, and verification compares d_out only when out_valid=1.
- occupancy is a registered counter:
  - +1 on an accept (in_valid & in_ready).
  - −1 on a drain (out_valid & out_ready).
  - Unchanged when both happen in the same cycle.
  - busy = (occupancy != 0).
- flush=1: all v[k] go to 0 and occupancy goes to 0 on the next edge. The input offered in that cycle is discarded even though in_ready may be 1. flush takes priority over both accept and drain.
- key_schedule is read by every stage every cycle. It must stay stable while busy=1, and the block does not check this. Changing the key while busy=1 corrupts the in-flight results.

## Timing
- Reset (n_rst=0): all S[k]=0, all v[k]=0, tags=0, occupancy=0. The outputs are therefore out_valid=0, d_out=0, tag_out=0, busy=0, in_ready=1.
- Reset asserted mid-operation discards all in-flight blocks immediately (asynchronous).
- Latency: a block accepted at edge t appears with out_valid=1 after edge t+NR. That is 11 cycles for NR=10, 13 for NR=12 and 15 for NR=14, measured from accept to first out_valid cycle with no stalls.
- Throughput: 1 block/cycle when out_ready is held at 1.
- out_valid, d_out and tag_out remain stable while out_valid=1 and out_ready=0.
- in_ready=0 only when all NR+1 stages are valid and out_ready=0.
- The longest combinational path is the adv chain, NR+1 gates deep, plus one round of logic.

## Test plan
- FIPS-197 C.1 (NR=10):
  - Stimulus: key 000102…0f, d_in 00112233445566778899aabbccddeeff, tag 0x5A, out_ready=1.
  - Response: d_out 69c4e0d86a7b0430d8cdb78070b4c55a and tag_out 0x5A, with out_valid rising 11 cycles after the accept.
- Key sizes:
  - NR=12, key 000102…17 → dda97ca4864cdfe06eaf70a0ec0d7191.
  - NR=14, key 000102…1f → 8ea2b7ca516745bfeafc49904b496089.
  - Latencies are 13 and 15 cycles respectively.
- Backpressure fill:
  - Stimulus: out_ready=0 with NR=10, streaming blocks with tags 0..12.
  - Response: exactly 11 blocks accepted, then in_ready=0 and occupancy=11.
  - Then raise out_ready: tags 0..10 emerge in order on consecutive cycles, and in_ready returns to 1 in the same cycle out_ready rises.
- Bubble collapse:
  - Stimulus: send blocks every other cycle with out_ready=0 until full.
  - Response: occupancy reaches 11 and the outputs match a reference model in order.
- Flush mid-stream:
  - Stimulus: 5 blocks in flight, then flush=1 for 1 cycle while in_valid=1.
  - Response: the next cycle has out_valid=0, occupancy=0, busy=0, and no result from the pre-flush blocks or the flush-cycle input ever appears.
- Async reset mid-stream:
  - Stimulus: pull n_rst low between edges with blocks in flight.
  - Response: out_valid and d_out go to 0 immediately, and after release the first new block gives a correct result with the full latency.

Source files
------------

// File: rtl/aes_enc_pipe.sv
// Fully unrolled AES encryption pipeline (AES-128/192/256 chosen by NR) with
// ready/valid flow control, bubble collapse, a sideband tag and synchronous flush.
module aes_enc_pipe #(
    parameter  int NR    = 10,
    parameter  int TAG_W = 8,
    localparam int NW    = 4 * (NR + 1),
    localparam int OCC_W = $clog2(NR + 2)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 flush,
    input  logic [32*NW-1:0]     key_schedule,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         d_in,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         d_out,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 busy,
    output logic [OCC_W-1:0]     occupancy
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_enc_pipe: NR must be 10, 12 or 14");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_enc_pipe: TAG_W must be at least 1");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state is row i%4, column i/4; ShiftRows rotates row r left by r.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        t = sub_shift(s);
        if (!last) begin
            t = {mix_col(t[127:96]), mix_col(t[95:64]), mix_col(t[63:32]), mix_col(t[31:0])};
        end
        return t ^ rk;
    endfunction

    function automatic logic [127:0] round_key(input logic [32*NW-1:0] ks, input int k);
        return ks[32*NW-1-128*k -: 128];
    endfunction

    logic [127:0]     state_q [NR+1];
    logic [127:0]     state_d [NR+1];
    logic [TAG_W-1:0] tag_q   [NR+1];
    logic [TAG_W-1:0] tag_d   [NR+1];
    logic [NR:0]      vld_q, vld_d;
    logic [NR:0]      adv;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             accept, drain;

    // A stage may load if it is empty or anything downstream of it can move.
    always_comb begin
        logic chain;
        chain   = !vld_q[NR] || out_ready;
        adv[NR] = chain;
        for (int k = NR - 1; k >= 0; k--) begin
            chain  = chain || !vld_q[k];
            adv[k] = chain;
        end
    end

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k <= NR; k++) begin
            state_d[k] = state_q[k];
            tag_d[k]   = tag_q[k];
        end
        // Stage 0: initial AddRoundKey
        if (adv[0]) begin
            state_d[0] = d_in ^ round_key(key_schedule, 0);
            tag_d[0]   = tag_in;
            vld_d[0]   = in_valid;
        end
        // Stages 1..NR: full rounds, last one without MixColumns
        for (int k = 1; k <= NR; k++) begin
            if (adv[k]) begin
                state_d[k] = enc_round(state_q[k-1], round_key(key_schedule, k), k == NR);
                tag_d[k]   = tag_q[k-1];
                vld_d[k]   = vld_q[k-1];
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    assign accept = in_valid && adv[0];
    assign drain  = vld_q[NR] && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !drain) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (drain && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k <= NR; k++) begin
                state_q[k] <= '0;
                tag_q[k]   <= '0;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            for (int k = 0; k <= NR; k++) begin
                state_q[k] <= state_d[k];
                tag_q[k]   <= tag_d[k];
            end
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[NR];
    assign d_out     = state_q[NR];
    assign tag_out   = tag_q[NR];
    assign busy      = (occ_q != '0);
    assign occupancy = occ_q;

endmodule

// File: tb/tb_aes_enc_pipe.sv
// Scoreboard bench for aes_enc_pipe: FIPS-197 known answers for all key sizes,
// backpressure fill, bubble collapse, flush and asynchronous reset.
module tb_aes_enc_pipe;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [127:0] d;
        logic [7:0]   t;
        int           acc;
        bit           lat;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic flush = 1'b0;
    logic [32*44-1:0] ks10 = '0;
    logic [32*52-1:0] ks12 = '0;
    logic [32*60-1:0] ks14 = '0;

    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
    logic [127:0] d_in = '0, d_out;
    logic [7:0]   tag_in = '0, tag_out;
    logic [3:0]   occupancy;

    logic         aux_rdy = 1'b1;
    logic         iv12 = 1'b0, ir12, ov12, busy12;
    logic [127:0] di12 = '0, do12;
    logic [7:0]   ti12 = '0, to12;
    logic [3:0]   occ12;
    logic         iv14 = 1'b0, ir14, ov14, busy14;
    logic [127:0] di14 = '0, do14;
    logic [7:0]   ti14 = '0, to14;
    logic [3:0]   occ14;

    aes_enc_pipe #(.NR(10), .TAG_W(8)) u_dut (
        .clk(clk), .n_rst(n_rst), .flush(flush), .key_schedule(ks10),
        .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .tag_out(tag_out),
        .busy(busy), .occupancy(occupancy)
    );

    aes_enc_pipe #(.NR(12), .TAG_W(8)) u_dut12 (
        .clk(clk), .n_rst(n_rst), .flush(flush), .key_schedule(ks12),
        .in_valid(iv12), .in_ready(ir12), .d_in(di12), .tag_in(ti12),
        .out_valid(ov12), .out_ready(aux_rdy), .d_out(do12), .tag_out(to12),
        .busy(busy12), .occupancy(occ12)
    );

    aes_enc_pipe #(.NR(14), .TAG_W(8)) u_dut14 (
        .clk(clk), .n_rst(n_rst), .flush(flush), .key_schedule(ks14),
        .in_valid(iv14), .in_ready(ir14), .d_in(di14), .tag_in(ti14),
        .out_valid(ov14), .out_ready(aux_rdy), .d_out(do14), .tag_out(to14),
        .busy(busy14), .occupancy(occ14)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [7:0]  sb [256];
    logic [31:0] wtmp [60];
    logic [31:0] w10 [44];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: S-box derived from GF(2^8) inversion plus affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Key bytes are 00,01,02,... for all key sizes.
    task automatic expand(input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) wtmp[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = wtmp[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wtmp[i] = wtmp[i-nk] ^ t;
        end
    endtask

    function automatic logic [7:0] rkb(input int rd, input int i);
        logic [31:0] w;
        w = w10[4*rd + i/4];
        return w[31-8*(i%4) -: 8];
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkb(0, i);
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sb[s[4*((c+row)%4)+row]];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb(rd, i);
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push0(input logic [127:0] exp, input logic [7:0] tg, input bit lat);
        exp_t e;
        e.d = exp; e.t = tg; e.acc = cyc; e.lat = lat;
        q0.push_back(e);
    endtask

    // Output monitor: pops on a handshake, otherwise checks the held result.
    task automatic check_out(input int which, input logic ov, input logic ordy,
                             input logic [127:0] d, input logic [7:0] t, input int nr);
        exp_t e;
        bit   ok;
        if (ov) begin
            ok = 1'b1;
            case (which)
                0: if (q0.size() == 0) ok = 1'b0; else e = ordy ? q0.pop_front() : q0[0];
                1: if (q1.size() == 0) ok = 1'b0; else e = ordy ? q1.pop_front() : q1[0];
                default: if (q2.size() == 0) ok = 1'b0; else e = ordy ? q2.pop_front() : q2[0];
            endcase
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL out%0d_unexpected: out_valid=1 d_out=%0h with nothing expected", which, d);
            end else begin
                chk($sformatf("out%0d_data_tag%0h", which, e.t), d, e.d);
                chk($sformatf("out%0d_tag", which), 128'(t), 128'(e.t));
                if (ordy && e.lat) chk($sformatf("out%0d_latency", which), 128'(cyc - e.acc), 128'(nr + 1));
            end
        end
    endtask

    always @(negedge clk) begin
        if (n_rst && !flush) begin
            check_out(0, out_valid, out_ready, d_out, tag_out, 10);
            check_out(1, ov12, aux_rdy, do12, to12, 12);
            check_out(2, ov14, aux_rdy, do14, to14, 14);
        end
    end

    task automatic send(input logic [127:0] pt, input logic [7:0] tg, input logic [127:0] exp,
                        input bit lat);
        int n;
        d_in = pt; tag_in = tg; in_valid = 1'b1; n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            push0(exp, tg, lat);
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_aux();
        exp_t e;
        di12 = PT; ti12 = 8'hc3; iv12 = 1'b1;
        di14 = PT; ti14 = 8'h3c; iv14 = 1'b1;
        @(negedge clk);
        chk("nr12_in_ready", 128'(ir12), 128'(1));
        chk("nr14_in_ready", 128'(ir14), 128'(1));
        e.acc = cyc; e.lat = 1'b1;
        if (ir12) begin e.d = CT12; e.t = 8'hc3; q1.push_back(e); end
        if (ir14) begin e.d = CT14; e.t = 8'h3c; q2.push_back(e); end
        @(posedge clk); #1;
        iv12 = 1'b0; iv14 = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results still expected, want 0",
                     q0.size() + q1.size() + q2.size());
            q0.delete(); q1.delete(); q2.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p, p11, p12;
        logic [7:0]   x;
        for (int i = 0; i < 256; i++) begin
            x     = ginv(8'(i));
            sb[i] = x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
        end
        expand(4);
        for (int i = 0; i < 44; i++) begin
            w10[i] = wtmp[i];
            ks10[32*44-1-32*i -: 32] = wtmp[i];
        end
        expand(6);
        for (int i = 0; i < 52; i++) ks12[32*52-1-32*i -: 32] = wtmp[i];
        expand(8);
        for (int i = 0; i < 60; i++) ks14[32*60-1-32*i -: 32] = wtmp[i];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_d_out", d_out, 128'(0));
        chk("rst_tag_out", 128'(tag_out), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_nr12_busy", 128'(busy12), 128'(0));
        chk("rst_nr14_occ", 128'(occ14), 128'(0));
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Known answers for all three key sizes, unstalled latency
        out_ready = 1'b1;
        send(PT, 8'h5a, CT10, 1'b1);
        send_aux();
        wait_drain(60);

        // Back-to-back stream at full throughput
        for (int i = 0; i < 4; i++) begin
            p = rnd128();
            send(p, 8'(8'h10 + i), aes_ref(p), 1'b1);
        end
        wait_drain(60);

        // Backpressure fill: 11 accepted, then stall
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            p = rnd128();
            send(p, 8'(i), aes_ref(p), 1'b0);
        end
        p11 = rnd128();
        d_in = p11; tag_in = 8'd11; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("fill_in_ready_low", 128'(in_ready), 128'(0));
            chk("fill_occupancy", 128'(occupancy), 128'(11));
        end
        chk("fill_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        p12 = rnd128();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("fill_out_valid_%0d", i), 128'(out_valid), 128'(1));
            if (i == 0) begin
                chk("fill_in_ready_rise", 128'(in_ready), 128'(1));
                if (in_ready) push0(aes_ref(p11), 8'd11, 1'b0);
            end
            if (i == 1 && in_ready) push0(aes_ref(p12), 8'd12, 1'b0);
            @(posedge clk); #1;
            if (i == 0) begin
                d_in = p12; tag_in = 8'd12;
            end else begin
                in_valid = 1'b0;
            end
        end
        wait_drain(60);

        // Bubble collapse: one block every other cycle while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            p = rnd128();
            send(p, 8'(8'h20 + i), aes_ref(p), 1'b0);
            chk($sformatf("bubble_occ_%0d", i), 128'(occupancy), 128'(i + 1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bubble_in_ready_low", 128'(in_ready), 128'(0));
        chk("bubble_occ_full", 128'(occupancy), 128'(11));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain(60);

        // Flush with five blocks in flight and a block offered in the flush cycle
        for (int i = 0; i < 5; i++) begin
            p = rnd128();
            send(p, 8'(8'h40 + i), aes_ref(p), 1'b0);
        end
        d_in = rnd128(); tag_in = 8'hee; in_valid = 1'b1; flush = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_occupancy", 128'(occupancy), 128'(0));
        chk("flush_busy", 128'(busy), 128'(0));
        repeat (25) @(negedge clk);
        chk("flush_occ_later", 128'(occupancy), 128'(0));
        @(posedge clk); #1;

        // Asynchronous reset with a full, stalled pipeline
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            p = rnd128();
            send(p, 8'(8'h60 + i), aes_ref(p), 1'b0);
        end
        @(negedge clk);
        chk("prerst_out_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #3;
        n_rst = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_d_out", d_out, 128'(0));
        chk("arst_tag_out", 128'(tag_out), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        q0.delete();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(PT, 8'h77, CT10, 1'b1);
        wait_drain(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
